// File: rtl/dp_sched_pkg.sv
// Shared types and constants for the datapath operation scheduler.
package dp_sched_pkg;

  localparam int N_REQ = 4;

  // {ctrl1,ctrl2} driven while nobody is granted; selects increment mode.
  localparam logic [3:0] DEF_IDLE_CODE = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // One-hot vector for a 2-bit requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/dp_op_scheduler_if.sv
// Requester-side bus of the scheduler: per-requester op/length posts in,
// grant/done and the datapath control selects out.
interface dp_op_scheduler_if #(
  parameter int LEN_W = 4
);
  logic [3:0]         req;
  logic [7:0]         req_ctrl1;
  logic [7:0]         req_ctrl2;
  logic [4*LEN_W-1:0] req_len;
  logic [3:0]         grant;
  logic [3:0]         done;
  logic [1:0]         ctrl1;
  logic [1:0]         ctrl2;
  logic               busy;

  // Requesting control logic side.
  modport master (
    output req, req_ctrl1, req_ctrl2, req_len,
    input  grant, done, ctrl1, ctrl2, busy
  );

  // Scheduler side.
  modport slave (
    input  req, req_ctrl1, req_ctrl2, req_len,
    output grant, done, ctrl1, ctrl2, busy
  );
endinterface

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request bit searching upward from ptr+1,
// wrapping modulo 4. Purely combinational.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  // Walk the four candidates in priority order; the first hit wins.
  always_comb begin
    logic [1:0] w_cand;
    found  = 1'b0;
    idx    = 2'd0;
    w_cand = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = ptr + 2'(k);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/dp_op_scheduler.sv
// Round-robin scheduler sharing the 4-bit op datapath among four requesters.
// A granted requester owns ctrl1/ctrl2 for its run length, then gets a
// one-cycle done pulse. All outputs come straight from registers.
module dp_op_scheduler
  import dp_sched_pkg::*;
#(
  parameter int         LEN_W     = 4,
  parameter logic [3:0] IDLE_CODE = DEF_IDLE_CODE
) (
  input  logic               clk,
  input  logic               rst,
  dp_op_scheduler_if.slave   bus
);

  sched_state_t r_state, w_stateNext;
  logic [1:0]       r_ptr, w_ptrNext;
  logic [1:0]       r_idx, w_idxNext;
  logic [3:0]       r_code, w_codeNext;
  logic [LEN_W-1:0] r_cnt, w_cntNext;
  logic [3:0]       r_grant, w_grantNext;
  logic [3:0]       r_done, w_doneNext;
  logic [3:0]       r_ctrl, w_ctrlNext;
  logic             r_busy, w_busyNext;

  logic             w_found;
  logic [1:0]       w_pickIdx;
  logic [3:0]       w_pickCode;
  logic [LEN_W-1:0] w_pickLen;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pickIdx)
  );

  // Pull the picked requester's op codes and run length out of the packed buses.
  always_comb begin
    w_pickCode = '0;
    w_pickLen  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pickIdx == k[1:0]) begin
        w_pickCode = {bus.req_ctrl1[2*k +: 2], bus.req_ctrl2[2*k +: 2]};
        w_pickLen  = bus.req_len[LEN_W*k +: LEN_W];
      end
    end
  end

  // Next state plus next output values; outputs default to the idle pattern.
  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_idxNext   = r_idx;
    w_codeNext  = r_code;
    w_cntNext   = r_cnt;
    w_grantNext = 4'b0000;
    w_doneNext  = 4'b0000;
    w_ctrlNext  = IDLE_CODE;
    w_busyNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNext = RUN;
          w_idxNext   = w_pickIdx;
          w_codeNext  = w_pickCode;
          w_cntNext   = (w_pickLen == '0) ? LEN_W'(1) : w_pickLen;
          w_grantNext = onehot4(w_pickIdx);
          w_ctrlNext  = w_pickCode;
          w_busyNext  = 1'b1;
        end
      end
      RUN: begin
        if (!bus.req[r_idx]) begin
          w_stateNext = IDLE;
          w_ptrNext   = r_idx;
        end else if (r_cnt == LEN_W'(1)) begin
          w_stateNext = DONE;
          w_cntNext   = r_cnt - LEN_W'(1);
          w_doneNext  = onehot4(r_idx);
          w_busyNext  = 1'b1;
        end else begin
          w_cntNext   = r_cnt - LEN_W'(1);
          w_grantNext = onehot4(r_idx);
          w_ctrlNext  = r_code;
          w_busyNext  = 1'b1;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
        w_ptrNext   = r_idx;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces idle with requester 0 first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd3;
      r_idx   <= 2'd0;
      r_code  <= IDLE_CODE;
      r_cnt   <= '0;
      r_grant <= 4'b0000;
      r_done  <= 4'b0000;
      r_ctrl  <= IDLE_CODE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_idx   <= w_idxNext;
      r_code  <= w_codeNext;
      r_cnt   <= w_cntNext;
      r_grant <= w_grantNext;
      r_done  <= w_doneNext;
      r_ctrl  <= w_ctrlNext;
      r_busy  <= w_busyNext;
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.ctrl1 = r_ctrl[3:2];
  assign bus.ctrl2 = r_ctrl[1:0];
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_dp_op_scheduler.sv
// Self-checking bench for dp_op_scheduler: directed scenarios followed by a
// random phase, all compared each cycle against a job-timeline model.
module tb_dp_op_scheduler;

  localparam int LEN_W = 4;
  localparam logic [3:0] IDLE_PAT = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dp_op_scheduler_if #(.LEN_W(LEN_W)) bus ();

  dp_op_scheduler #(.LEN_W(LEN_W), .IDLE_CODE(IDLE_PAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Model: a job granted at edge mStart with length mLen owns the datapath
  // for the periods following edges mStart..mStart+mLen-1, is done in the
  // period after edge mStart+mLen, and the period after that is idle.
  int         edgeNo = 0;
  bit         mActive = 0;
  int         mStart = 0;
  int         mLen = 1;
  int         mIdx = 0;
  int         mPtr = 3;
  logic [3:0] expGrant = 4'b0000;
  logic [3:0] expDone = 4'b0000;
  logic [3:0] expCtrl = IDLE_PAT;
  logic       expBusy = 1'b0;

  task automatic modelIdle();
    expGrant = 4'b0000;
    expDone  = 4'b0000;
    expCtrl  = IDLE_PAT;
    expBusy  = 1'b0;
  endtask

  // Advance the model at every rising edge using the inputs seen at that edge.
  always @(posedge clk) begin
    edgeNo++;
    if (rst) begin
      modelIdle();
      mPtr    = 3;
      mActive = 0;
    end else if (mActive) begin
      if (edgeNo <= mStart + mLen) begin
        if (!bus.req[mIdx]) begin
          modelIdle();
          mPtr    = mIdx;
          mActive = 0;
        end else if (edgeNo == mStart + mLen) begin
          expGrant = 4'b0000;
          expDone  = 4'b0001 << mIdx;
          expCtrl  = IDLE_PAT;
          expBusy  = 1'b1;
        end
      end else begin
        modelIdle();
        mPtr    = mIdx;
        mActive = 0;
      end
    end else begin
      modelIdle();
      for (int k = 1; k <= 4; k++) begin
        int cand;
        cand = (mPtr + k) % 4;
        if (!mActive && bus.req[cand]) begin
          int lenVal;
          lenVal   = int'(bus.req_len[LEN_W*cand +: LEN_W]);
          mActive  = 1;
          mIdx     = cand;
          mStart   = edgeNo;
          mLen     = (lenVal == 0) ? 1 : lenVal;
          expGrant = 4'b0001 << cand;
          expCtrl  = {bus.req_ctrl1[2*cand +: 2], bus.req_ctrl2[2*cand +: 2]};
          expBusy  = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput();
    checks++;
    assert (bus.grant === expGrant) else begin
      errors++;
      $error("[TB] FAIL grant @edge %0d: observed %b expected %b", edgeNo, bus.grant, expGrant);
    end
    checks++;
    assert (bus.done === expDone) else begin
      errors++;
      $error("[TB] FAIL done @edge %0d: observed %b expected %b", edgeNo, bus.done, expDone);
    end
    checks++;
    assert ({bus.ctrl1, bus.ctrl2} === expCtrl) else begin
      errors++;
      $error("[TB] FAIL ctrl @edge %0d: observed %b expected %b", edgeNo, {bus.ctrl1, bus.ctrl2}, expCtrl);
    end
    checks++;
    assert (bus.busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL busy @edge %0d: observed %b expected %b", edgeNo, bus.busy, expBusy);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq);
    rst     = r;
    bus.req = rq;
  endtask

  task automatic setOp(input int k, input logic [1:0] c1, input logic [1:0] c2,
                       input logic [LEN_W-1:0] len);
    bus.req_ctrl1[2*k +: 2]         = c1;
    bus.req_ctrl2[2*k +: 2]         = c2;
    bus.req_len[LEN_W*k +: LEN_W]   = len;
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    bus.req       = 4'b0000;
    bus.req_ctrl1 = 8'h00;
    bus.req_ctrl2 = 8'h00;
    bus.req_len   = '0;
    step(2);

    $display("[TB] idle after reset");
    applyStimulus(1'b0, 4'b0000);
    step(5);

    $display("[TB] single job, requester 1, len 3");
    setOp(1, 2'b01, 2'b10, 4'd3);
    applyStimulus(1'b0, 4'b0010);
    step(4);
    applyStimulus(1'b0, 4'b0000);
    step(3);

    $display("[TB] all requesting, len 1 round-robin");
    applyStimulus(1'b1, 4'b0000);
    step(1);
    for (int k = 0; k < 4; k++) setOp(k, 2'(k), 2'(3 - k), 4'd1);
    applyStimulus(1'b0, 4'b1111);
    step(15);
    applyStimulus(1'b0, 4'b0000);
    step(3);

    $display("[TB] abort of requester 2 mid-run");
    setOp(2, 2'b11, 2'b01, 4'd8);
    applyStimulus(1'b0, 4'b0100);
    step(4);
    applyStimulus(1'b0, 4'b0000);
    step(1);
    setOp(0, 2'b00, 2'b11, 4'd2);
    applyStimulus(1'b0, 4'b0101);
    step(3);
    applyStimulus(1'b0, 4'b0000);
    step(3);

    $display("[TB] zero length on requester 3");
    setOp(3, 2'b10, 2'b10, 4'd0);
    applyStimulus(1'b0, 4'b1000);
    step(2);
    applyStimulus(1'b0, 4'b0000);
    step(2);

    $display("[TB] reset during a run");
    setOp(2, 2'b01, 2'b01, 4'd5);
    applyStimulus(1'b0, 4'b0100);
    step(2);
    applyStimulus(1'b1, 4'b0000);
    step(1);
    setOp(0, 2'b01, 2'b00, 4'd1);
    setOp(3, 2'b11, 2'b11, 4'd1);
    applyStimulus(1'b0, 4'b1001);
    step(6);
    applyStimulus(1'b0, 4'b0000);
    step(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rq;
      rq = bus.req;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(5) == 0) rq[k] = ~rq[k];
        if ($urandom_range(7) == 0)
          setOp(k, 2'($urandom_range(3)), 2'($urandom_range(3)), 4'($urandom_range(6)));
      end
      applyStimulus(($urandom_range(63) == 0) ? 1'b1 : 1'b0, rq);
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_op_scheduler.md
# dp_op_scheduler

Round-robin scheduler that shares the 4-bit operation datapath (the `ctrl1`/`ctrl2`-selected bit-sum/increment/shift register) among four requesters. Each requester posts an operation code and a run length. The scheduler grants one requester at a time and drives the datapath's `ctrl1`/`ctrl2` for that many consecutive cycles. It then pulses that requester's `done` and moves on. It sits between requesting control logic and the datapath's control pins; data operands still go straight to the datapath.

## Interface
Parameters:
- `LEN_W`, default 4: width of each run-length field; maximum run is 2^LEN_W−1 cycles.
- `IDLE_CODE`, default 4'b1000: `{ctrl1,ctrl2}` driven when no requester is granted. The default selects increment mode.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  4  per-requester request level.
- `req_ctrl1`  in  8  requester k's ctrl1 code in bits [2k+1:2k].
- `req_ctrl2`  in  8  requester k's ctrl2 code in bits [2k+1:2k].
- `req_len`  in  4*LEN_W  requester k's run length in bits [LEN_W*k +: LEN_W].
- `grant`  out  4  one-hot grant; all zeros when idle.
- `done`  out  4  one-cycle completion pulse for the granted requester.
- `ctrl1`  out  2  datapath ctrl1 select.
- `ctrl2`  out  2  datapath ctrl2 select.
- `busy`  out  1  high in RUN and DONE states.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, `grant`=0, `done`=0, `busy`=0, `{ctrl1,ctrl2}`=IDLE_CODE, priority pointer=3. With pointer=3, requester 0 has the highest priority after reset.

IDLE:
- If `req`≠0, pick the first set bit searching upward from pointer+1 (mod 4).
- Latch that requester's index, ctrl1/ctrl2 codes and length into internal registers.
- Load the remaining-cycle counter with the length. A length of 0 is loaded as 1.
- Go to RUN.
- If `req`=0, stay in IDLE.

RUN:
- `grant[idx]`=1, `ctrl1`/`ctrl2` = latched codes, `busy`=1.
- The counter decrements every cycle.
- When counter==1, go to DONE.
- If `req[idx]` drops while in RUN, abort: go to IDLE, set pointer=idx, emit no `done`.
- Changes to other requesters' `req`/op/len during RUN are ignored. Op and length are sampled only at grant.

DONE:
- `done[idx]`=1 for exactly this cycle, `grant`=0, ctrl = IDLE_CODE, `busy`=1.
- Set pointer=idx, then go to IDLE.
- The requester must drop or re-assert `req` based on `done`. A `req` still high in IDLE is treated as a new request.

General rules:
- All outputs are registered. No combinational path runs from `req` to `grant`/`ctrl`.
- Counter width is LEN_W. It never underflows, because the exit is at 1 and zero is converted to 1.
- `rst` in any state returns all state and outputs to reset values at that edge, including in mid-RUN. No `done` is emitted.

## Timing
- A request sampled at edge t (scheduler in IDLE) gives `grant`/`ctrl` valid in cycle t+1.
- They stay valid for L cycles (L = max(len,1)), i.e. exactly L datapath register updates with the requested code.
- `done` is high in cycle t+L+1. IDLE follows in cycle t+L+2, and the next grant starts at t+L+3 at the earliest.
- Overhead is 2 cycles per job (DONE + IDLE arbitration).
- An abort detected at edge e (req low) gives IDLE in cycle e+1, with ctrl = IDLE_CODE and `grant`=0.
- Simultaneous requests are resolved in one cycle in IDLE, by round-robin from the pointer.

## Structure
- Shared package `dp_sched_pkg`:
  - state enum {IDLE, RUN, DONE}
  - `IDLE_CODE` default constant
  - `N_REQ`=4 constant
- Sub-module `rr_pick4`: combinational; inputs `req[3:0]`, `ptr[1:0]`; outputs `found` and `idx[1:0]`, searching from ptr+1 upward with wrap.
- The FSM, counter and output registers live in `dp_op_scheduler`.

## Test plan
- Reset, then hold `req`=0 for 5 cycles → `grant`=0, `busy`=0, `{ctrl1,ctrl2}`=4'b1000 throughout.
- `req`=4'b0010, req1 ctrl1=01, ctrl2=10, len=3 → `grant`=0010 with ctrl 01/10 for exactly 3 cycles, then `done`=0010 for 1 cycle, then idle code.
- `req`=4'b1111 held, all len=1 after reset → grant order 0,1,2,3,0 with `done` pulses matching; a new grant every 3 cycles.
- req2 granted with len=8, req2 dropped after 4 RUN cycles → IDLE next cycle, no `done`; a following `req`=0101 grants requester 0 (pointer=2).
- len=0 on requester 3 → exactly 1 RUN cycle, then `done`=1000.
- `rst` pulsed during the 2nd cycle of a len=5 run → next cycle all outputs at reset values; subsequent `req`=1001 grants requester 0 first.
